// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC transmit side: interval width, pulse-mode
// encodings and the pulse-pair generator state type.
package tdc_pkg;

  localparam int TDC_INTERVAL_W = 7;

  localparam logic [1:0] MODE_PAIR  = 2'b00;
  localparam logic [1:0] MODE_LEAD  = 2'b01;
  localparam logic [1:0] MODE_TRAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10,
    HOLD = 2'b11
  } gen_state_e;

endpackage

// File: rtl/tdc_pulse_window.sv
// Registered window generator: level is high while the elapsed count lies in
// [start, start + PULSE_W) and the window is enabled.
module tdc_pulse_window #(
  parameter int CNT_W   = 8,
  parameter int PULSE_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] start_i,
  output logic             level_o
);

  logic [CNT_W:0] stop;
  logic           level_q, level_d;

  // One extra bit so start + PULSE_W cannot wrap for the largest interval.
  assign stop = {1'b0, start_i} + (CNT_W+1)'(PULSE_W);

  always_comb begin
    level_d = en_i && ({1'b0, cnt_i} >= {1'b0, start_i}) && ({1'b0, cnt_i} < stop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/tdc_pulse_pair_gen.sv
// Start/stop pulse pair generator for TDC calibration and loopback: emits a
// leading and a trailing pulse a programmed number of clk cycles apart.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RUN   | pulse windows active, elapsed counter running
// DONE  | one-cycle done strobe, sent_count just incremented
// HOLD  | HOLDOFF idle cycles before accepting again
module tdc_pulse_pair_gen
  import tdc_pkg::*;
#(
  parameter int INTERVAL_W = TDC_INTERVAL_W,
  parameter int PULSE_W    = 1,
  parameter int HOLDOFF    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [INTERVAL_W-1:0] req_interval,
  input  logic                  req_swap,
  input  logic [1:0]            req_mode,
  output logic                  pulse1,
  output logic                  pulse2,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      sent_count
);

  localparam int EW = INTERVAL_W + 1;

  gen_state_e            state_q, state_d;
  logic [INTERVAL_W-1:0] ivl_q, ivl_d;
  logic                  swap_q, swap_d;
  logic [1:0]            mode_q, mode_d;
  logic [EW-1:0]         elap_q, elap_d;
  logic [CNT_W-1:0]      sent_q, sent_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic          accept;
  logic          lead_en, trail_en, run_q;
  logic [EW-1:0] elap_inc, trail_start, last_cnt;
  logic          p1_en, p2_en;
  logic [EW-1:0] p1_start, p2_start;

  assign accept      = req_valid && ready_q;
  assign run_q       = (state_q == RUN);
  assign lead_en     = (mode_q != MODE_TRAIL);
  assign trail_en    = (mode_q != MODE_LEAD);
  assign elap_inc    = (elap_q == {EW{1'b1}}) ? elap_q : elap_q + EW'(1);
  assign trail_start = EW'(ivl_q) + EW'(1);
  // Elapsed value one past the final high cycle of the last emitted pulse.
  assign last_cnt    = (trail_en ? EW'(ivl_q) : EW'(0)) + EW'(PULSE_W) + EW'(1);

  always_comb begin
    state_d = state_q;
    ivl_d   = ivl_q;
    swap_d  = swap_q;
    mode_d  = mode_q;
    elap_d  = elap_q;
    sent_d  = sent_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          ivl_d   = req_interval;
          swap_d  = req_swap;
          mode_d  = req_mode;
          elap_d  = EW'(1);
        end
      end
      RUN: begin
        if (elap_q >= last_cnt) begin
          state_d = DONE;
          sent_d  = sent_q + CNT_W'(1);
        end else begin
          elap_d = elap_inc;
        end
      end
      DONE: begin
        elap_d  = EW'(1);
        state_d = (HOLDOFF > 0) ? HOLD : IDLE;
      end
      HOLD: begin
        if (elap_q >= EW'(HOLDOFF)) begin
          state_d = IDLE;
        end else begin
          elap_d = elap_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_q != IDLE) && (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ivl_q   <= '0;
      swap_q  <= 1'b0;
      mode_q  <= MODE_PAIR;
      elap_q  <= '0;
      sent_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ivl_q   <= ivl_d;
      swap_q  <= swap_d;
      mode_q  <= mode_d;
      elap_q  <= elap_d;
      sent_q  <= sent_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // swap selects which physical output carries the leading window.
  assign p1_en    = run_q && (swap_q ? trail_en : lead_en);
  assign p2_en    = run_q && (swap_q ? lead_en : trail_en);
  assign p1_start = swap_q ? trail_start : EW'(1);
  assign p2_start = swap_q ? EW'(1) : trail_start;

  tdc_pulse_window #(.CNT_W(EW), .PULSE_W(PULSE_W)) u_win1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (p1_en),
    .cnt_i   (elap_q),
    .start_i (p1_start),
    .level_o (pulse1)
  );

  tdc_pulse_window #(.CNT_W(EW), .PULSE_W(PULSE_W)) u_win2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (p2_en),
    .cnt_i   (elap_q),
    .start_i (p2_start),
    .level_o (pulse2)
  );

  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sent_count = sent_q;

endmodule

// File: tb/tb_tdc_pulse_pair_gen.sv
// Bench for tdc_pulse_pair_gen: cycle-window model checked every cycle plus
// literal timing checks for the directed scenarios.
module tb_tdc_pulse_pair_gen;
  import tdc_pkg::*;

  localparam int IW = 7;
  localparam int PW = 3;
  localparam int HO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] req_interval = '0;
  logic          req_swap = 1'b0;
  logic [1:0]    req_mode = 2'b00;
  logic          pulse1, pulse2, busy, done;
  logic [CW-1:0] sent_count;

  always #5 clk = ~clk;

  tdc_pulse_pair_gen #(
    .INTERVAL_W (IW),
    .PULSE_W    (PW),
    .HOLDOFF    (HO),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_interval (req_interval),
    .req_swap     (req_swap),
    .req_mode     (req_mode),
    .pulse1       (pulse1),
    .pulse2       (pulse2),
    .busy         (busy),
    .done         (done),
    .sent_count   (sent_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: cycle n is the interval following rising edge n; a request accepted
  // on edge T0 owns absolute cycle windows derived from its latched fields.
  int         cyc = 0;
  bit         m_oor, m_have, m_swap;
  int         m_t0, m_i, m_cnt, acc_n;
  logic [1:0] m_mode;
  bit         e_p1, e_p2, e_busy, e_done, e_ready;
  int         m_len, m_dcyc;
  bit         m_lo, m_tr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_oor = 0; m_have = 0; m_cnt = 0;
      e_p1 = 0; e_p2 = 0; e_busy = 0; e_done = 0; e_ready = 0;
    end else begin
      cyc++;
      if (e_ready && req_valid) begin
        m_have = 1; m_t0 = cyc; m_i = int'(req_interval);
        m_swap = req_swap; m_mode = req_mode; acc_n++;
      end
      m_oor = 1;
      e_p1 = 0; e_p2 = 0; e_busy = 0; e_done = 0; e_ready = m_oor;
      if (m_have) begin
        m_len  = (m_mode == MODE_LEAD) ? PW : m_i + PW;
        m_dcyc = m_t0 + m_len + 1;
        m_lo   = (m_mode != MODE_TRAIL) && cyc >= m_t0 + 1 && cyc <= m_t0 + PW;
        m_tr   = (m_mode != MODE_LEAD) && cyc >= m_t0 + 1 + m_i && cyc <= m_t0 + m_i + PW;
        e_p1   = m_swap ? m_tr : m_lo;
        e_p2   = m_swap ? m_lo : m_tr;
        e_done = (cyc == m_dcyc);
        if (e_done) m_cnt = (m_cnt + 1) % (1 << CW);
        e_busy  = cyc >= m_t0 + 1 && cyc <= m_dcyc + HO;
        e_ready = !(cyc >= m_t0 && cyc <= m_dcyc + HO);
      end
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    if ({pulse1, pulse2, busy, done, req_ready} !== {e_p1, e_p2, e_busy, e_done, e_ready}
        || sent_count !== CW'(m_cnt)) begin
      n_bad++;
      $display("FAIL cycle %0d outputs p1,p2,busy,done,ready/count: got %b%b%b%b%b/%0d expected %b%b%b%b%b/%0d",
               cyc, pulse1, pulse2, busy, done, req_ready, sent_count,
               e_p1, e_p2, e_busy, e_done, e_ready, m_cnt);
    end
  end

  // Event capture for literal checks: first rise cycles and done strobes.
  int r1, r2, n_done, dfirst, dlast;
  bit p1_prev, p2_prev;
  always @(negedge clk) begin
    if (pulse1 === 1'b1 && !p1_prev && r1 < 0) r1 = cyc;
    if (pulse2 === 1'b1 && !p2_prev && r2 < 0) r2 = cyc;
    if (done === 1'b1) begin
      if (n_done == 0) dfirst = cyc;
      dlast = cyc;
      n_done++;
    end
    p1_prev = (pulse1 === 1'b1);
    p2_prev = (pulse2 === 1'b1);
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic clear_capture();
    r1 = -1; r2 = -1; n_done = 0; dfirst = -1; dlast = -1;
  endtask

  task automatic wait_accept(input int target, output int t0);
    int n = 0;
    while (acc_n < target && n < 200) begin @(negedge clk); n++; end
    if (acc_n < target) chk("accept timeout", acc_n, target);
    t0 = m_t0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (!e_ready && n < 400);
    if (!e_ready) chk("idle timeout", 0, 1);
  endtask

  task automatic run_req(input int iv, input bit sw, input logic [1:0] md, output int t0);
    int a0;
    @(negedge clk);
    clear_capture();
    a0 = acc_n;
    req_valid = 1'b1; req_interval = IW'(iv); req_swap = sw; req_mode = md;
    wait_accept(a0 + 1, t0);
    // Scramble the fields after accept; the latched copy must be used.
    req_valid = 1'b0; req_interval = ~req_interval; req_swap = ~sw; req_mode = ~md;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t0a, t0b, a0;
    clear_capture();
    #2 rst_n = 1'b0;
    #1;
    chk("reset req_ready", req_ready, 0);
    chk("reset sent_count", sent_count, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("ready before first edge", req_ready, 0);
    @(negedge clk);
    chk("ready after first edge", req_ready, 1);

    run_req(10, 0, MODE_PAIR, t0);
    chk("I10 pulse1 rise", r1 - t0, 1);
    chk("I10 pulse2 rise", r2 - t0, 11);
    chk("I10 measured interval", r2 - r1, 10);
    chk("I10 done", dlast - t0, 14);
    chk("I10 done count", n_done, 1);
    chk("I10 sent_count", sent_count, 1);

    run_req(0, 0, MODE_PAIR, t0);
    chk("I0 measured interval", r2 - r1, 0);
    chk("I0 pulse1 rise", r1 - t0, 1);

    run_req(5, 1, MODE_PAIR, t0);
    chk("swap pulse2 rise", r2 - t0, 1);
    chk("swap pulse1 rise", r1 - t0, 6);

    run_req(9, 0, MODE_LEAD, t0);
    chk("lead-only pulse1 rise", r1 - t0, 1);
    chk("lead-only pulse2 absent", r2, -1);
    chk("lead-only done", dlast - t0, 4);

    run_req(4, 0, MODE_TRAIL, t0);
    chk("trail-only pulse1 absent", r1, -1);
    chk("trail-only pulse2 rise", r2 - t0, 5);
    chk("trail-only done", dlast - t0, 8);

    run_req(127, 0, MODE_PAIR, t0);
    chk("I127 pulse2 rise", r2 - t0, 128);
    chk("I127 done", dlast - t0, 131);
    chk("I127 sent_count", sent_count, 6);

    // req_valid held high across two requests.
    @(negedge clk);
    clear_capture();
    a0 = acc_n;
    req_valid = 1'b1; req_interval = 7'd2; req_swap = 1'b0; req_mode = MODE_PAIR;
    wait_accept(a0 + 1, t0a);
    wait_accept(a0 + 2, t0b);
    req_valid = 1'b0;
    chk("first done after accept", dfirst - t0a, 6);
    // Ready returns HOLDOFF+1 cycles after done; the accepting edge closes that cycle.
    chk("back-to-back accept edge", t0b - dfirst, HO + 2);
    wait_idle();
    chk("back-to-back done count", n_done, 2);

    run_req(1, 0, MODE_PAIR, t0);
    chk("overlap interval", r2 - r1, 1);
    chk("overlap done", dlast - t0, 5);
    chk("sent before abort", sent_count, 9);

    // Abort a request while pulse2 is high.
    @(negedge clk);
    clear_capture();
    a0 = acc_n;
    req_valid = 1'b1; req_interval = 7'd2; req_swap = 1'b0; req_mode = MODE_PAIR;
    wait_accept(a0 + 1, t0);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pulse2 high before abort", pulse2, 1);
    rst_n = 1'b0;
    #1;
    chk("abort pulse1", pulse1, 0);
    chk("abort pulse2", pulse2, 0);
    chk("abort busy", busy, 0);
    chk("abort ready", req_ready, 0);
    chk("abort sent_count", sent_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready one edge after release", req_ready, 1);
    repeat (10) @(negedge clk);
    chk("no done after abort", n_done, 0);
    chk("sent after abort", sent_count, 0);

    // Fill the 4-bit counter to its maximum, then wrap it.
    for (int k = 0; k < 15; k++) run_req(0, 0, MODE_LEAD, t0);
    chk("sent at max", sent_count, 15);
    run_req(3, 0, MODE_PAIR, t0);
    chk("sent wrapped", sent_count, 0);
    chk("wrap done count", n_done, 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
